nested_ifs_cfg_ctrl: RTL
========================

# nested_ifs_cfg_ctrl

- Configuration controller for the nested-if stateful atom.
- Accepts per-field configuration writes into a shadow bank over a valid/ready port.
- On commit, drains in-flight packets, then atomically swaps shadow into the active bank that drives the atom's constant, selector, relational-op and arithmetic-op inputs.
- Sits between the control-plane loader and the atom, and gates the atom's packet-valid path.

## Interface
Parameters:
- DRAIN_CYCLES, 2, cycles packets are blocked before swap (atom pipeline depth); 0 legal
- CFG_AW, 6, config address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i__cfg_valid  in  1  config write request
- o__cfg_ready  out  1  write accepted when valid&ready
- i__cfg_addr  in  CFG_AW  field index (map below)
- i__cfg_data  in  32  field value
- o__cfg_err  out  1  sticky: a write hit an unmapped address
- i__commit  in  1  commit request (sampled in IDLE only)
- i__clr_state  in  1  sampled with i__commit; requests atom state clear
- o__commit_done  out  1  one-cycle pulse, new config active
- o__state_clr  out  1  one-cycle pulse to zero atom state_1
- o__busy  out  1  FSM not IDLE
- i__pkt_valid  in  1  upstream packet valid
- o__pkt_ready  out  1  upstream may issue
- o__pkt_valid  out  1  packet valid to atom = i__pkt_valid & o__pkt_ready
- o__cons  out  11x32  active cons_1..cons_11
- o__sel  out  21x2  active sel_1..sel_21 (1-bit selectors use bit 0, bit 1 forced 0)
- o__rel_op  out  3x2  active rel_op1..3
- o__arith_op  out  4x1  active arith_op1..4

## Operation
- Address map: 0–10 cons_1..11 (data[31:0]); 11–31 sel_1..21 (data[1:0] for sel_8,9,11,12,17,18,20,21, else data[0]); 32–34 rel_op1..3 (data[1:0]); 35–38 arith_op1..4 (data[0]); 39+ unmapped.
- Unmapped write: accepted, dropped, sets o__cfg_err; cleared in SWAP.
- FSM states IDLE, DRAIN, SWAP.
- IDLE: cfg_ready=1, pkt_ready=1. On i__commit go to DRAIN (SWAP if DRAIN_CYCLES=0), loading drain counter with DRAIN_CYCLES and latching i__clr_state.
- DRAIN: cfg_ready=0, pkt_ready=0; counter decrements each cycle; at 1 go to SWAP.
- SWAP: cfg_ready=0, pkt_ready=0; active <= shadow at cycle end; next state IDLE.
- Write and commit in the same IDLE cycle: the write lands in shadow and is included in that commit.
- i__commit outside IDLE is ignored; the source waits for o__commit_done.
- Shadow retains contents after commit; partial rewrite plus commit is legal.
- Active bank changes only in SWAP; never mid-packet.

## Timing
- Reset (async assert, sync deassert internally): state IDLE, shadow and active all zero, o__cfg_ready=1, o__pkt_ready=1, all other outputs 0.
- Reset mid-DRAIN/SWAP: abandons commit; active returns to zero.
- Commit sampled at end of cycle T:
  - T+1..T+D: DRAIN (D=DRAIN_CYCLES).
  - T+D+1: SWAP.
  - T+D+2: IDLE, new active visible, o__commit_done=1, o__state_clr=1 if latched.
- pkt_ready low for exactly D+1 cycles per commit.
- Config write: 1 cycle into shadow; zero effect on outputs until commit.
- o__pkt_valid combinational from i__pkt_valid and state; all other outputs registered.

## Structure
- Shared package atom_pkg: int32_t, int2_t, bool typedefs; NUM_CONS=11, NUM_SEL=21, NUM_REL=3, NUM_ARITH=4; field base-address constants; sel-width mask (which selectors are 2-bit).
- Sub-module atom_cfg_bank: shadow+active register arrays with write port, field masking and swap strobe. The FSM and drain counter stay in the top.

## Test plan
- Reset then idle: all o__cons/o__sel/o__rel_op/o__arith_op 0, cfg_ready=1, pkt_ready=1, busy=0.
- Write addr 0 = 0x0000_0005, addr 18 (sel_8) = 3, addr 11 (sel_1) = 3, then commit with DRAIN_CYCLES=2 -> pkt_ready low 3 cycles, commit_done at T+4, cons_1=5, sel_8=2'b11, sel_1=2'b01.
- Write to addr 50 -> cfg_err=1, no bank change; commit -> cfg_err clears in SWAP.
- i__pkt_valid held high across commit -> o__pkt_valid low exactly D+1 cycles, active unchanged until SWAP ends.
- Write to addr 36 = 1 and commit in the same cycle, i__clr_state=1 -> arith_op2=1 after commit; o__state_clr pulses with commit_done.
- Commit pulsed during DRAIN ignored; rst_n asserted mid-DRAIN -> active stays zero, FSM IDLE, no commit_done.

Source files
------------

// File: rtl/atom_pkg.sv
// Shared types, field address map and selector-width mask for the
// nested-if stateful atom and its configuration controller.
package atom_pkg;

  typedef logic signed [31:0] int32_t;
  typedef logic [1:0]         int2_t;
  typedef logic               bool;

  localparam int NUM_CONS  = 11;
  localparam int NUM_SEL   = 21;
  localparam int NUM_REL   = 3;
  localparam int NUM_ARITH = 4;

  localparam int CONS_BASE  = 0;
  localparam int SEL_BASE   = 11;
  localparam int REL_BASE   = 32;
  localparam int ARITH_BASE = 35;
  localparam int ADDR_END   = 39;

  // Bit k set means sel_(k+1) is a 2-bit selector (sel_8,9,11,12,17,18,20,21).
  localparam logic [NUM_SEL-1:0] SEL_WIDE_MASK = 21'h1B0D80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SWAP
  } cfg_state_e;

  function automatic int2_t sel_field(input int idx, input logic [31:0] data);
    return SEL_WIDE_MASK[idx] ? data[1:0] : {1'b0, data[0]};
  endfunction

endpackage

// File: rtl/atom_cfg_bank.sv
// Shadow/active configuration banks: field-masked writes land in shadow,
// a swap strobe copies the whole shadow into the active bank in one cycle.
module atom_cfg_bank
  import atom_pkg::*;
#(
  parameter int CFG_AW = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CFG_AW-1:0]       wr_addr,
  input  logic [31:0]             wr_data,
  input  logic                    swap,
  output logic [NUM_CONS*32-1:0]  cons,
  output logic [NUM_SEL*2-1:0]    sel,
  output logic [NUM_REL*2-1:0]    rel_op,
  output logic [NUM_ARITH-1:0]    arith_op,
  output logic                    cfg_err
);

  int32_t shadow_cons_q [NUM_CONS];
  int32_t shadow_cons_d [NUM_CONS];
  int32_t active_cons_q [NUM_CONS];
  int32_t active_cons_d [NUM_CONS];
  int2_t  shadow_sel_q  [NUM_SEL];
  int2_t  shadow_sel_d  [NUM_SEL];
  int2_t  active_sel_q  [NUM_SEL];
  int2_t  active_sel_d  [NUM_SEL];
  int2_t  shadow_rel_q  [NUM_REL];
  int2_t  shadow_rel_d  [NUM_REL];
  int2_t  active_rel_q  [NUM_REL];
  int2_t  active_rel_d  [NUM_REL];
  logic [NUM_ARITH-1:0] shadow_arith_q, shadow_arith_d;
  logic [NUM_ARITH-1:0] active_arith_q, active_arith_d;
  logic cfg_err_q, cfg_err_d;

  logic [31:0] addr_ext;
  assign addr_ext = 32'(wr_addr);

  always_comb begin
    shadow_cons_d  = shadow_cons_q;
    shadow_sel_d   = shadow_sel_q;
    shadow_rel_d   = shadow_rel_q;
    shadow_arith_d = shadow_arith_q;
    active_cons_d  = active_cons_q;
    active_sel_d   = active_sel_q;
    active_rel_d   = active_rel_q;
    active_arith_d = active_arith_q;
    cfg_err_d      = cfg_err_q;
    if (wr_en) begin
      for (int i = 0; i < NUM_CONS; i++)
        if (addr_ext == 32'(CONS_BASE + i)) shadow_cons_d[i] = int32_t'(wr_data);
      for (int i = 0; i < NUM_SEL; i++)
        if (addr_ext == 32'(SEL_BASE + i)) shadow_sel_d[i] = sel_field(i, wr_data);
      for (int i = 0; i < NUM_REL; i++)
        if (addr_ext == 32'(REL_BASE + i)) shadow_rel_d[i] = wr_data[1:0];
      for (int i = 0; i < NUM_ARITH; i++)
        if (addr_ext == 32'(ARITH_BASE + i)) shadow_arith_d[i] = wr_data[0];
      // Unmapped writes are still accepted; they only raise the sticky flag.
      if (addr_ext >= 32'(ADDR_END)) cfg_err_d = 1'b1;
    end
    if (swap) begin
      active_cons_d  = shadow_cons_q;
      active_sel_d   = shadow_sel_q;
      active_rel_d   = shadow_rel_q;
      active_arith_d = shadow_arith_q;
      cfg_err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CONS; i++) begin
        shadow_cons_q[i] <= '0;
        active_cons_q[i] <= '0;
      end
      for (int i = 0; i < NUM_SEL; i++) begin
        shadow_sel_q[i] <= '0;
        active_sel_q[i] <= '0;
      end
      for (int i = 0; i < NUM_REL; i++) begin
        shadow_rel_q[i] <= '0;
        active_rel_q[i] <= '0;
      end
      shadow_arith_q <= '0;
      active_arith_q <= '0;
      cfg_err_q      <= 1'b0;
    end else begin
      shadow_cons_q  <= shadow_cons_d;
      active_cons_q  <= active_cons_d;
      shadow_sel_q   <= shadow_sel_d;
      active_sel_q   <= active_sel_d;
      shadow_rel_q   <= shadow_rel_d;
      active_rel_q   <= active_rel_d;
      shadow_arith_q <= shadow_arith_d;
      active_arith_q <= active_arith_d;
      cfg_err_q      <= cfg_err_d;
    end
  end

  always_comb begin
    cons   = '0;
    sel    = '0;
    rel_op = '0;
    for (int i = 0; i < NUM_CONS; i++) cons[i*32 +: 32] = active_cons_q[i];
    for (int i = 0; i < NUM_SEL; i++)  sel[i*2 +: 2]     = active_sel_q[i];
    for (int i = 0; i < NUM_REL; i++)  rel_op[i*2 +: 2]  = active_rel_q[i];
  end

  assign arith_op = active_arith_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: rtl/nested_ifs_cfg_ctrl.sv
// Commit controller for the nested-if atom: blocks packets for the atom's
// pipeline depth, then swaps the shadow configuration into the active bank.
module nested_ifs_cfg_ctrl
  import atom_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CFG_AW       = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i__cfg_valid,
  output logic                    o__cfg_ready,
  input  logic [CFG_AW-1:0]       i__cfg_addr,
  input  logic [31:0]             i__cfg_data,
  output logic                    o__cfg_err,
  input  logic                    i__commit,
  input  logic                    i__clr_state,
  output logic                    o__commit_done,
  output logic                    o__state_clr,
  output logic                    o__busy,
  input  logic                    i__pkt_valid,
  output logic                    o__pkt_ready,
  output logic                    o__pkt_valid,
  output logic [NUM_CONS*32-1:0]  o__cons,
  output logic [NUM_SEL*2-1:0]    o__sel,
  output logic [NUM_REL*2-1:0]    o__rel_op,
  output logic [NUM_ARITH-1:0]    o__arith_op
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  // Reset asserts immediately but releases two clocks after rst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bool              clr_q, clr_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic             pkt_ready_q, pkt_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             state_clr_q, state_clr_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_d       = clr_q;
    done_d      = 1'b0;
    state_clr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i__commit) begin
          cnt_d   = CNT_W'(DRAIN_CYCLES);
          clr_d   = i__clr_state;
          state_d = (DRAIN_CYCLES == 0) ? ST_SWAP : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q <= CNT_W'(1)) state_d = ST_SWAP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_SWAP: begin
        state_d     = ST_IDLE;
        done_d      = 1'b1;
        state_clr_d = clr_q;
        clr_d       = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE);
    pkt_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      clr_q       <= 1'b0;
      cfg_ready_q <= 1'b1;
      pkt_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      state_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clr_q       <= clr_d;
      cfg_ready_q <= cfg_ready_d;
      pkt_ready_q <= pkt_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      state_clr_q <= state_clr_d;
    end
  end

  atom_cfg_bank #(.CFG_AW(CFG_AW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_int_n),
    .wr_en    (i__cfg_valid & cfg_ready_q),
    .wr_addr  (i__cfg_addr),
    .wr_data  (i__cfg_data),
    .swap     (state_q == ST_SWAP),
    .cons     (o__cons),
    .sel      (o__sel),
    .rel_op   (o__rel_op),
    .arith_op (o__arith_op),
    .cfg_err  (o__cfg_err)
  );

  assign o__cfg_ready   = cfg_ready_q;
  assign o__pkt_ready   = pkt_ready_q;
  assign o__pkt_valid   = i__pkt_valid & pkt_ready_q;
  assign o__busy        = busy_q;
  assign o__commit_done = done_q;
  assign o__state_clr   = state_clr_q;

endmodule
